eth_fcs_check_wide: RTL and testbench



---
 rtl/eth_fcs_check_wide_pkg.sv | 33 +++
 rtl/eth_fcs_check_wide_if.sv | 32 +++
 rtl/eth_fcs_check_wide_crc32_lanes.sv | 37 +++
 rtl/eth_fcs_check_wide.sv | 120 ++++++++++++
 tb/tb_eth_fcs_check_wide.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_fcs_check_wide_pkg.sv
// Shared CRC32 constants, byte-step function, status record and FSM state type
// for the wide Ethernet FCS checker.
package eth_crc_pkg;

  localparam logic [31:0] POLY_CRC    = 32'hEDB8_8320;
  localparam logic [31:0] INIT_CRC    = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE_CRC = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REPORT = 2'd2
  } fcs_state_t;

  typedef struct packed {
    logic crc_ok;
    logic crc_err;
    logic runt;
    logic giant;
    logic keep_err;
  } fcs_status_t;

  // Reflected CRC32 update, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_CRC) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_fcs_check_wide_if.sv
// Receive stream plus per-frame status record of the wide FCS checker.
// Handshake: no ready; every cycle with s_valid=1 is one transferred beat.
// status_valid is a one-cycle pulse; the status_* fields hold until the next pulse.
interface eth_fcs_check_wide_if #(
  parameter int BYTES = 4,
  parameter int LEN_W = 16
);
  logic               s_valid;
  logic [8*BYTES-1:0] s_data;
  logic [BYTES-1:0]   s_keep;
  logic               s_last;

  logic               status_valid;
  logic               status_crc_ok;
  logic               status_crc_err;
  logic               status_runt;
  logic               status_giant;
  logic               status_keep_err;
  logic [LEN_W-1:0]   status_len;

  modport master (
    output s_valid, s_data, s_keep, s_last,
    input  status_valid, status_crc_ok, status_crc_err, status_runt,
    input  status_giant, status_keep_err, status_len
  );

  modport slave (
    input  s_valid, s_data, s_keep, s_last,
    output status_valid, status_crc_ok, status_crc_err, status_runt,
    output status_giant, status_keep_err, status_len
  );
endinterface

// File: rtl/eth_fcs_check_wide_crc32_lanes.sv
// Combinational fold of the kept byte lanes of one beat into the running CRC.
// Lanes at and above the first cleared keep bit are ignored.
module crc32_lanes
  import eth_crc_pkg::*;
#(
  parameter  int BYTES = 4,
  localparam int CNT_W = $clog2(BYTES + 1)
) (
  input  logic [31:0]        crc_in,
  input  logic [8*BYTES-1:0] data,
  input  logic [BYTES-1:0]   keep,
  output logic [31:0]        crc_out,
  output logic [CNT_W-1:0]   count,
  output logic               contig
);

  logic [BYTES-1:0] mask;

  always_comb begin
    logic run;
    run     = 1'b1;
    crc_out = crc_in;
    count   = '0;
    mask    = '0;
    for (int i = 0; i < BYTES; i++) begin
      run     = run & keep[i];
      mask[i] = run;
      if (run) begin
        crc_out = crc32_byte(crc_out, data[8*i +: 8]);
        count   = count + CNT_W'(1);
      end
    end
    // Legal keep is a run of ones from lane 0 with nothing set above it.
    contig = (mask == keep);
  end

endmodule

// File: rtl/eth_fcs_check_wide.sv
// Wide Ethernet RX FCS checker (residue method), one status record per frame.
// Optional FCS_STATS_EN adds saturating good/bad frame counters with stat_clr.
module eth_fcs_check_wide
  import eth_crc_pkg::*;
#(
  parameter int BYTES   = 4,
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  eth_fcs_check_wide_if.slave  s,
`ifdef FCS_STATS_EN
  input  logic                 stat_clr,
  output logic [31:0]          stat_good,
  output logic [31:0]          stat_bad,
`endif
  output fcs_state_t           dbg_state
);

  localparam int CNT_W = $clog2(BYTES + 1);

  fcs_state_t       state;
  logic [31:0]      crc_reg;
  logic [LEN_W-1:0] len;
  logic             keep_err_acc;

  logic             status_valid_q;
  fcs_status_t      status_q;
  logic [LEN_W-1:0] status_len_q;

  logic [31:0]      crc_next;
  logic [CNT_W-1:0] lane_cnt;
  logic             lane_contig;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] len_next;
  logic             kerr_next;
  fcs_status_t      stat_next;

  crc32_lanes #(.BYTES(BYTES)) u_lanes (
    .crc_in  (crc_reg),
    .data    (s.s_data),
    .keep    (s.s_keep),
    .crc_out (crc_next),
    .count   (lane_cnt),
    .contig  (lane_contig)
  );

  always_comb begin
    len_sum   = {1'b0, len} + (LEN_W+1)'(lane_cnt);
    len_next  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    kerr_next = keep_err_acc |
                (s.s_last ? !lane_contig : (s.s_keep != {BYTES{1'b1}}));
    stat_next.keep_err = kerr_next;
    stat_next.crc_ok   = (crc_next == RESIDUE_CRC) && !kerr_next;
    stat_next.crc_err  = !((crc_next == RESIDUE_CRC) && !kerr_next);
    stat_next.runt     = 32'(len_next) < 32'(MIN_LEN);
    stat_next.giant    = 32'(len_next) > 32'(MAX_LEN);
  end

  // Accumulators are cleared on the s_last beat itself, so a beat arriving in
  // REPORT folds into INIT without any special casing; no beat is ever lost.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= ST_IDLE;
      crc_reg        <= INIT_CRC;
      len            <= '0;
      keep_err_acc   <= 1'b0;
      status_valid_q <= 1'b0;
      status_q       <= '0;
      status_len_q   <= '0;
    end else begin
      status_valid_q <= 1'b0;
      if (s.s_valid) begin
        if (s.s_last) begin
          state          <= ST_REPORT;
          status_valid_q <= 1'b1;
          status_q       <= stat_next;
          status_len_q   <= len_next;
          crc_reg        <= INIT_CRC;
          len            <= '0;
          keep_err_acc   <= 1'b0;
        end else begin
          state          <= ST_ACTIVE;
          crc_reg        <= crc_next;
          len            <= len_next;
          keep_err_acc   <= kerr_next;
        end
      end else if (state == ST_REPORT) begin
        state <= ST_IDLE;
      end
    end
  end

  assign s.status_valid    = status_valid_q;
  assign s.status_crc_ok   = status_q.crc_ok;
  assign s.status_crc_err  = status_q.crc_err;
  assign s.status_runt     = status_q.runt;
  assign s.status_giant    = status_q.giant;
  assign s.status_keep_err = status_q.keep_err;
  assign s.status_len      = status_len_q;
  assign dbg_state         = state;

`ifdef FCS_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_good <= '0;
      stat_bad  <= '0;
    end else if (stat_clr) begin
      stat_good <= '0;
      stat_bad  <= '0;
    end else if (status_valid_q) begin
      if (status_q.crc_ok && (stat_good != '1)) stat_good <= stat_good + 32'd1;
      if (status_q.crc_err && (stat_bad != '1)) stat_bad <= stat_bad + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_fcs_check_wide.sv
// Bench for eth_fcs_check_wide: random frames scored against a byte-level model
// that checks the FCS field directly; a LEN_W=8 copy watches length saturation.
module tb_eth_fcs_check_wide;
  import eth_crc_pkg::*;

  localparam int RW = 21;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  logic [7:0]    frame_q[$];
  logic [31:0]   bd_q[$];
  logic [3:0]    bk_q[$];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp8_q[$];
  int            exp_cyc_q[$];
  logic [RW-1:0] last_rec;
  logic [RW-1:0] last_rec8;

  fcs_state_t dbg_state, dbg_state8;

  eth_fcs_check_wide_if #(.BYTES(4), .LEN_W(16)) bus ();
  eth_fcs_check_wide_if #(.BYTES(4), .LEN_W(8))  bus8 ();

  assign bus8.s_valid = bus.s_valid;
  assign bus8.s_data  = bus.s_data;
  assign bus8.s_keep  = bus.s_keep;
  assign bus8.s_last  = bus.s_last;

`ifdef FCS_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_good, stat_bad, stat_good8, stat_bad8;
`endif

  eth_fcs_check_wide #(.BYTES(4), .LEN_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .s(bus),
`ifdef FCS_STATS_EN
    .stat_clr(stat_clr), .stat_good(stat_good), .stat_bad(stat_bad),
`endif
    .dbg_state(dbg_state)
  );

  eth_fcs_check_wide #(.BYTES(4), .LEN_W(8)) dut8 (
    .aclk(aclk), .aresetn(aresetn), .s(bus8),
`ifdef FCS_STATS_EN
    .stat_clr(stat_clr), .stat_good(stat_good8), .stat_bad(stat_bad8),
`endif
    .dbg_state(dbg_state8)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_crc(input logic [7:0] q[$], input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected record for the beats in bd_q/bk_q; len_max models the counter width.
  function automatic logic [RW-1:0] model(input int len_max);
    logic [7:0]  d[$];
    logic [31:0] fcs;
    bit          kerr = 0;
    bit          ok = 0;
    bit          last;
    int          j, n, ln;
    for (int b = 0; b < bd_q.size(); b++) begin
      last = (b == bd_q.size() - 1);
      if (!last && bk_q[b] != 4'hF) kerr = 1;
      j = 0;
      while (j < 4 && bk_q[b][j]) begin
        d.push_back(bd_q[b][8*j +: 8]);
        j++;
      end
      if (last) for (int k = j; k < 4; k++) if (bk_q[b][k]) kerr = 1;
    end
    n = d.size();
    if (n >= 4) begin
      fcs = {d[n-1], d[n-2], d[n-3], d[n-4]};
      ok  = (ref_crc(d, n - 4) == fcs);
    end
    ok = ok && !kerr;
    ln = (n > len_max) ? len_max : n;
    return {ok, !ok, ln < 64, ln > 1522, kerr, 16'(ln)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic make_frame(input int payload);
    logic [31:0] c;
    frame_q.delete();
    for (int i = 0; i < payload; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    c = ref_crc(frame_q, payload);
    for (int i = 0; i < 4; i++) frame_q.push_back(c[8*i +: 8]);
  endtask

  task automatic build_beats();
    logic [31:0] w;
    logic [3:0]  k;
    bd_q.delete();
    bk_q.delete();
    for (int i = 0; i < frame_q.size(); i += 4) begin
      w = $urandom();
      k = '0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < frame_q.size()) begin
          w[8*j +: 8] = frame_q[i + j];
          k[j] = 1'b1;
        end
      end
      bd_q.push_back(w);
      bk_q.push_back(k);
    end
  endtask

  // Called and returns #1 after a rising edge.
  task automatic send_frame(input bit gaps, input bit hold, input bit with_last);
    int nb;
    nb = bd_q.size();
    if (with_last) begin
      exp_q.push_back(model(65535));
      exp8_q.push_back(model(255));
    end
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0) begin
        repeat ($urandom_range(0, 2)) begin
          bus.s_valid = 1'b0;
          @(posedge aclk); #1;
        end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = bd_q[b];
      bus.s_keep  = bk_q[b];
      bus.s_last  = with_last && (b == nb - 1);
      if (bus.s_last) exp_cyc_q.push_back(cyc + 1);
      @(posedge aclk); #1;
    end
    if (!hold) begin
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
    end
  endtask

  task automatic drain();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_status pending=%0d pending8=%0d required=0", exp_q.size(), exp8_q.size());
      exp_q.delete(); exp8_q.delete(); exp_cyc_q.delete();
    end
  endtask

  task automatic load_known();
    frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge aclk) begin : mon
    logic [RW-1:0] got, e;
    int ec;
    if (aresetn && bus.status_valid) begin
      n_pulses++;
      got = {bus.status_crc_ok, bus.status_crc_err, bus.status_runt, bus.status_giant,
             bus.status_keep_err, bus.status_len};
      last_rec = got;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_status got=%h required=none", got);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL status_rec got=%h required=%h", got, e);
        end
        n_checks++;
        if (cyc != ec) begin
          n_fail++;
          $display("FAIL status_latency got_cycle=%0d required=%0d", cyc, ec);
        end
      end
    end
  end

  always @(negedge aclk) begin : mon8
    logic [RW-1:0] got, e;
    if (aresetn && bus8.status_valid) begin
      got = {bus8.status_crc_ok, bus8.status_crc_err, bus8.status_runt, bus8.status_giant,
             bus8.status_keep_err, 8'h00, bus8.status_len};
      last_rec8 = got;
      n_checks++;
      if (exp8_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_status8 got=%h required=none", got);
      end else begin
        e = exp8_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL status_rec8 got=%h required=%h", got, e);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_keep = '0; bus.s_last = 1'b0;
`ifdef FCS_STATS_EN
    stat_clr = 1'b0;
`endif
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if (bus.status_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b required=0", bus.status_valid);
    end
    n_checks++;
    if ({bus.status_crc_ok, bus.status_crc_err, bus.status_runt, bus.status_giant,
         bus.status_keep_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b%b%b%b%b required=00000", bus.status_crc_ok,
        bus.status_crc_err, bus.status_runt, bus.status_giant, bus.status_keep_err);
    end
    n_checks++;
    if (bus.status_len !== 16'd0 || bus8.status_len !== 8'd0) begin
      n_fail++; $display("FAIL reset_len got=%0d/%0d required=0", bus.status_len, bus8.status_len);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE || dbg_state8 !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state got=%0d/%0d required=%0d", dbg_state, dbg_state8, ST_IDLE);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_known_vector();
    load_known();
    build_beats();
    send_frame(1'b0, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (last_rec !== {5'b10100, 16'd13}) begin
      n_fail++; $display("FAIL known_vector got=%h required=%h", last_rec, {5'b10100, 16'd13});
    end
  endtask

  task automatic test_crc_err();
    load_known();
    frame_q[3] = frame_q[3] ^ 8'h01;
    build_beats();
    send_frame(1'b0, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (last_rec !== {5'b01100, 16'd13}) begin
      n_fail++; $display("FAIL crc_err got=%h required=%h", last_rec, {5'b01100, 16'd13});
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = n_pulses;
    make_frame(60); build_beats(); send_frame(1'b0, 1'b1, 1'b1);
    make_frame(60); build_beats(); send_frame(1'b0, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (n_pulses - p0 != 2) begin
      n_fail++; $display("FAIL b2b_pulses got=%0d required=2", n_pulses - p0);
    end
    n_checks++;
    if (last_rec !== {5'b10000, 16'd64}) begin
      n_fail++; $display("FAIL b2b_second got=%h required=%h", last_rec, {5'b10000, 16'd64});
    end
  endtask

  task automatic test_keep();
    make_frame(60); build_beats();
    bk_q[bk_q.size() - 1] = 4'b1011;
    send_frame(1'b0, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (last_rec[19] !== 1'b1 || last_rec[16] !== 1'b1 || last_rec[20] !== 1'b0) begin
      n_fail++; $display("FAIL keep_last_noncontig got=%h required=err+keep_err", last_rec);
    end
    make_frame(60); build_beats();
    bk_q[2] = 4'b0111;
    send_frame(1'b1, 1'b0, 1'b1);
    make_frame(60); build_beats();
    bd_q.push_back($urandom());
    bk_q.push_back(4'b0000);
    send_frame(1'b1, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (last_rec !== {5'b10000, 16'd64}) begin
      n_fail++; $display("FAIL keep_zero_last got=%h required=%h", last_rec, {5'b10000, 16'd64});
    end
  endtask

  task automatic test_giant();
    make_frame(1596); build_beats();
    send_frame(1'b0, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (last_rec !== {5'b10010, 16'd1600}) begin
      n_fail++; $display("FAIL giant got=%h required=%h", last_rec, {5'b10010, 16'd1600});
    end
    n_checks++;
    if (last_rec8 !== {5'b10000, 16'd255}) begin
      n_fail++; $display("FAIL len_saturate got=%h required=%h", last_rec8, {5'b10000, 16'd255});
    end
  endtask

  task automatic test_random();
    int bi;
    for (int f = 0; f < 30; f++) begin
      make_frame($urandom_range(0, 120));
      if ($urandom_range(0, 3) == 0) begin
        bi = $urandom_range(0, frame_q.size() - 1);
        frame_q[bi] = frame_q[bi] ^ (8'h01 << $urandom_range(0, 7));
      end
      build_beats();
      if ($urandom_range(0, 7) == 0) bk_q[$urandom_range(0, bk_q.size() - 1)] = 4'($urandom_range(0, 15));
      send_frame($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
    end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    make_frame(40); build_beats();
    while (bd_q.size() > 3) begin
      void'(bd_q.pop_back());
      void'(bk_q.pop_back());
    end
    send_frame(1'b0, 1'b1, 1'b0);
    #2 aresetn = 1'b0;
    bus.s_valid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    load_known(); build_beats();
    send_frame(1'b0, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (last_rec !== {5'b10100, 16'd13}) begin
      n_fail++; $display("FAIL after_reset got=%h required=%h", last_rec, {5'b10100, 16'd13});
    end
`ifdef FCS_STATS_EN
    n_checks++;
    if (stat_good !== 32'd1 || stat_bad !== 32'd0) begin
      n_fail++; $display("FAIL stats_after_reset got=%0d/%0d required=1/0", stat_good, stat_bad);
    end
    stat_clr = 1'b1;
    @(posedge aclk); #1;
    stat_clr = 1'b0;
    n_checks++;
    if (stat_good !== 32'd0 || stat_bad !== 32'd0) begin
      n_fail++; $display("FAIL stats_clear got=%0d/%0d required=0/0", stat_good, stat_bad);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_crc_err();
    test_back_to_back();
    test_keep();
    test_giant();
    test_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout cycle=%0d required=finish", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
